rop_frag_serializer: RTL and testbench

- Sits directly upstream of the ROP depth/stencil stage.
- Accepts per-warp ROP requests (tmask, pos_x, pos_y, color, depth, backface per lane) from the core's ROP issue path and buffers them in a FIFO.
- Emits one fragment per cycle, for active lanes only, in ascending lane order.
- Converts warp-wide traffic into the single-fragment stream that the per-fragment pipeline consumes.

---
 rtl/rop_frag_serializer.sv | 126 ++++++++++++
 tb/tb_rop_frag_serializer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rop_frag_serializer.sv
// Warp-to-fragment serializer feeding the ROP depth/stencil stage: buffers
// per-warp requests and emits active lanes one per cycle, lowest lane first.

module rop_frag_lane (
   input  logic rem_bit,
   input  logic lower_any,
   output logic sel,
   output logic lower_any_out
);
   assign sel           = rem_bit & ~lower_any;
   assign lower_any_out = lower_any | rem_bit;
endmodule

module rop_frag_serializer #(
   parameter int NUM_LANES  = 4,
   parameter int DIM_BITS   = 12,
   parameter int DEPTH_BITS = 24,
   parameter int QUEUE_SIZE = 4,
   parameter int LANE_BITS  = $clog2(NUM_LANES),
   parameter int CNT_BITS   = $clog2(QUEUE_SIZE + 1)
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            req_valid,
   input  logic [NUM_LANES-1:0]            req_tmask,
   input  logic [NUM_LANES*DIM_BITS-1:0]   req_pos_x,
   input  logic [NUM_LANES*DIM_BITS-1:0]   req_pos_y,
   input  logic [NUM_LANES*32-1:0]         req_color,
   input  logic [NUM_LANES*DEPTH_BITS-1:0] req_depth,
   input  logic [NUM_LANES-1:0]            req_backface,
   output logic                            req_ready,
   output logic                            frag_valid,
   output logic [DIM_BITS-1:0]             frag_pos_x,
   output logic [DIM_BITS-1:0]             frag_pos_y,
   output logic [31:0]                     frag_color,
   output logic [DEPTH_BITS-1:0]           frag_depth,
   output logic                            frag_backface,
   output logic [LANE_BITS-1:0]            frag_lane,
   output logic                            frag_last,
   input  logic                            frag_ready,
   output logic [CNT_BITS-1:0]             count,
   output logic                            empty
);
   localparam int PTR_BITS = $clog2(QUEUE_SIZE);

   typedef struct packed {
      logic [NUM_LANES-1:0]                 tmask;
      logic [NUM_LANES-1:0]                 backface;
      logic [NUM_LANES-1:0][DIM_BITS-1:0]   pos_x;
      logic [NUM_LANES-1:0][DIM_BITS-1:0]   pos_y;
      logic [NUM_LANES-1:0][31:0]           color;
      logic [NUM_LANES-1:0][DEPTH_BITS-1:0] depth;
   } entry_t;

   entry_t               mem [QUEUE_SIZE];
   entry_t               head;
   logic [PTR_BITS-1:0]  head_ptr, tail_ptr;
   logic [NUM_LANES-1:0] served, remaining, sel;
   logic [NUM_LANES:0]   lower_chain;
   logic [LANE_BITS-1:0] lane_idx;
   logic                 push, pop, frag_fire, last_raw;

   assign head      = mem[head_ptr];
   assign empty     = (count == '0);
   assign req_ready = (count != CNT_BITS'(QUEUE_SIZE));
   assign push      = req_valid & req_ready & (|req_tmask);
   assign remaining = head.tmask & ~served;

   // Lowest-set-bit pick: each lane fires only if no lower lane is still pending.
   assign lower_chain[0] = 1'b0;
   rop_frag_lane u_lane [NUM_LANES-1:0] (
      .rem_bit       (remaining),
      .lower_any     (lower_chain[NUM_LANES-1:0]),
      .sel           (sel),
      .lower_any_out (lower_chain[NUM_LANES:1])
   );

   always_comb begin
      lane_idx = '0;
      for (int i = 0; i < NUM_LANES; i++)
         if (sel[i]) lane_idx = LANE_BITS'(i);
   end

   assign last_raw      = ((remaining & (remaining - NUM_LANES'(1))) == '0);
   assign frag_valid    = !empty;
   assign frag_fire     = frag_valid & frag_ready;
   assign pop           = frag_fire & last_raw;
   assign frag_lane     = frag_valid ? lane_idx : '0;
   assign frag_last     = frag_valid & last_raw;
   assign frag_pos_x    = frag_valid ? head.pos_x[lane_idx] : '0;
   assign frag_pos_y    = frag_valid ? head.pos_y[lane_idx] : '0;
   assign frag_color    = frag_valid ? head.color[lane_idx] : '0;
   assign frag_depth    = frag_valid ? head.depth[lane_idx] : '0;
   assign frag_backface = frag_valid & head.backface[lane_idx];

   always_ff @(posedge clk) begin
      if (push) mem[tail_ptr] <= '{tmask: req_tmask, backface: req_backface,
                                    pos_x: req_pos_x, pos_y: req_pos_y,
                                    color: req_color, depth: req_depth};
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_ptr <= '0;
         tail_ptr <= '0;
         count    <= '0;
         served   <= '0;
      end else begin
         if (push) tail_ptr <= tail_ptr + PTR_BITS'(1);
         if (pop)  head_ptr <= head_ptr + PTR_BITS'(1);
         if (frag_fire) served <= last_raw ? '0 : (served | sel);
         count <= count + CNT_BITS'(push) - CNT_BITS'(pop);
      end
   end

   logic [DIM_BITS*2+32+DEPTH_BITS+LANE_BITS+1:0] frag_bus;
   assign frag_bus = {frag_pos_x, frag_pos_y, frag_color, frag_depth,
                      frag_backface, frag_lane, frag_last};

   a_head_live: assert property (@(posedge clk) disable iff (!reset_n)
      !empty |-> (head.tmask != '0) && lower_chain[NUM_LANES]);
   a_count_rng: assert property (@(posedge clk) disable iff (!reset_n)
      count <= CNT_BITS'(QUEUE_SIZE));
   a_stall:     assert property (@(posedge clk) disable iff (!reset_n)
      (frag_valid && !frag_ready) |=> (frag_valid && $stable(frag_bus)));
endmodule

// File: tb/tb_rop_frag_serializer.sv
// Randomized bench for rop_frag_serializer against a fragment-queue reference model.

module tb_rop_frag_serializer;
   localparam int NL = 4, DB = 12, ZB = 24, QS = 4;

   logic clk = 1'b0;
   logic reset_n, req_valid, req_ready, frag_valid, frag_backface, frag_last, frag_ready, empty;
   logic [NL-1:0]    req_tmask, req_backface;
   logic [NL*DB-1:0] req_pos_x, req_pos_y;
   logic [NL*32-1:0] req_color;
   logic [NL*ZB-1:0] req_depth;
   logic [DB-1:0]    frag_pos_x, frag_pos_y;
   logic [31:0]      frag_color;
   logic [ZB-1:0]    frag_depth;
   logic [1:0]       frag_lane;
   logic [2:0]       count;

   always #5 clk = ~clk;

   rop_frag_serializer dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_tmask(req_tmask),
      .req_pos_x(req_pos_x), .req_pos_y(req_pos_y), .req_color(req_color),
      .req_depth(req_depth), .req_backface(req_backface), .req_ready(req_ready),
      .frag_valid(frag_valid), .frag_pos_x(frag_pos_x), .frag_pos_y(frag_pos_y),
      .frag_color(frag_color), .frag_depth(frag_depth), .frag_backface(frag_backface),
      .frag_lane(frag_lane), .frag_last(frag_last), .frag_ready(frag_ready),
      .count(count), .empty(empty)
   );

   typedef struct {
      logic [DB-1:0] x, y;
      logic [31:0]   c;
      logic [ZB-1:0] d;
      logic          bf;
      int            lane;
      logic          last;
   } frag_t;

   frag_t q[$];
   int    mcount = 0;
   int    total = 0, bad = 0, fires = 0;
   bit    acc;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic new_req(input logic [NL-1:0] tm);
      req_tmask = tm;
      for (int i = 0; i < NL; i++) begin
         req_pos_x[i*DB +: DB] = DB'($urandom);
         req_pos_y[i*DB +: DB] = DB'($urandom);
         req_color[i*32 +: 32] = $urandom;
         req_depth[i*ZB +: ZB] = ZB'($urandom);
         req_backface[i]       = 1'($urandom);
      end
   endtask

   // A request expands to its active lanes in ascending order; the highest one is last.
   task automatic enqueue_model();
      frag_t f;
      int hi = -1;
      for (int l = 0; l < NL; l++) if (req_tmask[l]) hi = l;
      for (int l = 0; l < NL; l++) begin
         if (req_tmask[l]) begin
            f.x = req_pos_x[l*DB +: DB];
            f.y = req_pos_y[l*DB +: DB];
            f.c = req_color[l*32 +: 32];
            f.d = req_depth[l*ZB +: ZB];
            f.bf = req_backface[l];
            f.lane = l;
            f.last = (l == hi);
            q.push_back(f);
         end
      end
   endtask

   task automatic step(input logic v, input logic fr);
      frag_t f;
      req_valid  = v;
      frag_ready = fr;
      #3;
      check("count", 64'(count), 64'(mcount));
      check("empty", 64'(empty), 64'(mcount == 0));
      check("req_ready", 64'(req_ready), 64'(mcount != QS));
      check("frag_valid", 64'(frag_valid), 64'(q.size() != 0));
      if (q.size() != 0) begin
         f = q[0];
         check("frag_lane", 64'(frag_lane), 64'(f.lane));
         check("frag_pos_x", 64'(frag_pos_x), 64'(f.x));
         check("frag_pos_y", 64'(frag_pos_y), 64'(f.y));
         check("frag_color", 64'(frag_color), 64'(f.c));
         check("frag_depth", 64'(frag_depth), 64'(f.d));
         check("frag_backface", 64'(frag_backface), 64'(f.bf));
         check("frag_last", 64'(frag_last), 64'(f.last));
      end else begin
         check("idle_data", {frag_pos_x, frag_pos_y, frag_depth, frag_lane, frag_last, frag_backface}, 64'd0);
         check("idle_color", 64'(frag_color), 64'd0);
      end
      acc = v && (mcount != QS);
      if (q.size() != 0 && fr) begin
         f = q.pop_front();
         fires++;
         if (f.last) mcount--;
      end
      if (acc && req_tmask != '0) begin
         enqueue_model();
         mcount++;
      end
      @(posedge clk); #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         step(1'b0, 1'b1);
         n++;
      end
      check("drain_done", 64'(q.size()), 64'd0);
      step(1'b0, 1'b1);
   endtask

   initial begin
      int n, accepted;
      logic hold, v;
      reset_n = 1'b0; req_valid = 1'b0; frag_ready = 1'b0;
      new_req('0);
      repeat (2) @(posedge clk);
      #1;
      check("rst_count", 64'(count), 64'd0);
      check("rst_empty", 64'(empty), 64'd1);
      check("rst_req_ready", 64'(req_ready), 64'd1);
      check("rst_frag_valid", 64'(frag_valid), 64'd0);
      reset_n = 1'b1;

      // Single request with known x coordinates.
      new_req(4'b1011);
      req_pos_x = {12'd40, 12'd30, 12'd20, 12'd10};
      step(1'b1, 1'b1);
      fires = 0;
      repeat (3) step(1'b0, 1'b1);
      check("t1_fires", 64'(fires), 64'd3);
      step(1'b0, 1'b1);

      // Empty-mask request is swallowed.
      new_req(4'b0000);
      step(1'b1, 1'b1);
      repeat (2) step(1'b0, 1'b1);

      // Fill, back-pressure, then release.
      for (int i = 0; i < QS; i++) begin
         new_req(4'hf);
         step(1'b1, 1'b0);
      end
      new_req(4'hf);
      step(1'b1, 1'b0);
      check("fill_blocked", 64'(acc), 64'd0);
      fires = 0;
      n = 0;
      acc = 1'b0;
      while (!acc && n < 20) begin
         step(1'b1, 1'b1);
         n++;
      end
      check("fifth_accept_cycle", 64'(n), 64'd5);
      drain();
      check("fill_fires", 64'(fires), 64'd20);

      // Stall stability with toggling frag_ready.
      new_req(4'b0110);
      step(1'b1, 1'b0);
      fires = 0;
      for (int i = 0; i < 8; i++) step(1'b0, 1'(i % 2));
      check("stall_fires", 64'(fires), 64'd2);

      // Random stream wrapping the pointers.
      accepted = 0; n = 0; hold = 1'b0;
      while (accepted < 10 && n < 400) begin
         if (!hold) new_req(4'($urandom_range(1, 15)));
         v = 1'($urandom_range(0, 1));
         step(v, 1'($urandom_range(0, 1)));
         if (acc) accepted++;
         hold = v && !acc;
         n++;
      end
      check("wrap_accepted", 64'(accepted), 64'd10);
      drain();

      // Reset in the middle of a request.
      new_req(4'hf);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      reset_n = 1'b0;
      #1;
      check("midrst_frag_valid", 64'(frag_valid), 64'd0);
      check("midrst_count", 64'(count), 64'd0);
      check("midrst_req_ready", 64'(req_ready), 64'd1);
      q.delete();
      mcount = 0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      new_req(4'b0001);
      step(1'b1, 1'b1);
      fires = 0;
      repeat (2) step(1'b0, 1'b1);
      check("post_rst_fires", 64'(fires), 64'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
endmodule
